// File: rtl/mm_pkg.sv
// mm_pkg: shared constants for the UART matrix-multiply sequencer.
//   - 3-bit state encodings (also visible on the debug "state" output)
//   - default frame-start and error-reply bytes
//   - mm_addr_w(): element-address width for a MAX_N x MAX_N matrix
package mm_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SIZE    = 3'd1;
  localparam logic [2:0] ST_RECV_A  = 3'd2;
  localparam logic [2:0] ST_RECV_B  = 3'd3;
  localparam logic [2:0] ST_START   = 3'd4;
  localparam logic [2:0] ST_COMPUTE = 3'd5;
  localparam logic [2:0] ST_SEND    = 3'd6;
  localparam logic [2:0] ST_ERR     = 3'd7;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ERR_BYTE_DEF  = 8'hEE;

  // Width of a row-major element index for up to max_n*max_n elements.
  function automatic int mm_addr_w(input int max_n);
    return $clog2(max_n * max_n);
  endfunction

endpackage

// File: rtl/mm_byte_counter.sv
// mm_byte_counter: up-counter that wraps to zero after reaching a run-time
// limit. Used for the element index (rx writes and tx reads) and for the byte
// index inside a transmitted result word.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear (wins over inc_i)
//   inc_i       advance by one; wraps to 0 when count_o == limit_i
//   limit_i     last value of the count sequence
//   count_o     current count
//   last_o      count_o == limit_i (combinational)
module mm_byte_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign last_o  = (count_q == limit_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = last_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mm_seq_controller.sv
// mm_seq_controller: frames the host byte stream (SYNC, size N, N*N bytes of
// A, N*N bytes of B) into A/B RAM writes, pulses the multiplier, then streams
// the N*N results back RES_BYTES bytes per element, MSB first. A bad size byte
// or an inter-byte timeout inside a frame produces a single error reply.
//
// Handshakes:
//   rx_valid is a one-cycle strobe; a byte is consumed in the cycle it is
//   strobed if rx_enable is high, otherwise it is silently dropped.
//   tx_start is a one-cycle strobe issued only when tx_ready is high and no
//   strobe was issued the previous cycle, because tx_ready only falls one
//   cycle after the transmitter accepts a byte.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rx_valid, rx_data       received byte strobe and data
//   rx_enable               controller accepts bytes (IDLE/SIZE/RECV_A/RECV_B)
//   tx_ready                transmitter idle
//   tx_start, tx_err        send strobe; tx_err selects ERR_BYTE
//   tx_byte_sel             byte of result word to send (0 = MSB)
//   res_addr                result RAM read address
//   wr_en_a, wr_en_b        write rx_data into A/B RAM at wr_addr
//   wr_addr                 row-major element index of the current A/B byte
//   mult_start, mult_done   multiplier start pulse / completion
//   matrix_size             latched N
//   state                   FSM state (debug)
//   error                   sticky error flag, cleared by the next SYNC byte
module mm_seq_controller
  import mm_pkg::*;
#(
  parameter int         MAX_N     = 8,
  parameter int         RES_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [7:0] ERR_BYTE  = ERR_BYTE_DEF,
  parameter int         TIMEOUT   = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          rx_enable,
  input  logic                          tx_ready,
  output logic                          tx_start,
  output logic                          tx_err,
  output logic [1:0]                    tx_byte_sel,
  output logic [mm_addr_w(MAX_N)-1:0]   res_addr,
  output logic                          wr_en_a,
  output logic                          wr_en_b,
  output logic [mm_addr_w(MAX_N)-1:0]   wr_addr,
  output logic                          mult_start,
  input  logic                          mult_done,
  output logic [3:0]                    matrix_size,
  output logic [2:0]                    state,
  output logic                          error
);

  localparam int         AW     = mm_addr_w(MAX_N);
  localparam int         BW     = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
  localparam int         TW     = $clog2(TIMEOUT);
  localparam logic [3:0] MAX_N4 = 4'(MAX_N);

  // Elaboration-time guard on the parameter set; the error reply byte must be
  // distinguishable from the frame-start byte on the host side.
  if (MAX_N < 2 || MAX_N > 15 || RES_BYTES < 1 || RES_BYTES > 4 ||
      TIMEOUT < 2 || SYNC_BYTE == ERR_BYTE) begin : g_param_check
    $error("mm_seq_controller: illegal parameter set");
  end

  logic [2:0]    state_q, state_d;
  logic [3:0]    n_q, n_d;
  logic          error_q, error_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tx_pend_q;

  logic          tmo_run;
  logic          tmo_hit;
  logic          size_ok;
  logic          cnt_clr;
  logic          elem_inc;
  logic          bsel_inc;
  logic [7:0]    nn;
  logic [AW-1:0] elem_limit;
  logic [AW-1:0] elem;
  logic          elem_last;
  logic [BW-1:0] bsel;
  logic          bsel_last;

  // N*N-1 fits AW bits for every legal N, so the cast drops only zeros.
  assign nn         = {4'b0, n_q} * {4'b0, n_q};
  assign elem_limit = AW'(nn - 8'd1);

  assign size_ok = (rx_data[7:4] == 4'd0) && (rx_data[3:0] >= 4'd2) &&
                   (rx_data[3:0] <= MAX_N4);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  // Both counters restart on every state change, so each phase (RECV_A,
  // RECV_B, SEND) begins at element 0 / byte 0.
  assign cnt_clr = (state_d != state_q);

  mm_byte_counter #(.W(AW)) u_elem_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .inc_i   (elem_inc),
    .limit_i (elem_limit),
    .count_o (elem),
    .last_o  (elem_last)
  );

  mm_byte_counter #(.W(BW)) u_bsel_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .inc_i   (bsel_inc),
    .limit_i (BW'(RES_BYTES - 1)),
    .count_o (bsel),
    .last_o  (bsel_last)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    error_d    = error_q;
    tmo_run    = 1'b0;
    elem_inc   = 1'b0;
    bsel_inc   = 1'b0;
    rx_enable  = 1'b0;
    wr_en_a    = 1'b0;
    wr_en_b    = 1'b0;
    mult_start = 1'b0;
    tx_start   = 1'b0;
    tx_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rx_enable = 1'b1;
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_SIZE;
          error_d = 1'b0;
        end
      end
      ST_SIZE: begin
        rx_enable = 1'b1;
        tmo_run   = 1'b1;
        if (rx_valid) begin
          if (size_ok) begin
            n_d     = rx_data[3:0];
            state_d = ST_RECV_A;
          end else begin
            state_d = ST_ERR;
          end
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_RECV_A: begin
        rx_enable = 1'b1;
        tmo_run   = 1'b1;
        if (rx_valid) begin
          wr_en_a  = 1'b1;
          elem_inc = 1'b1;
          if (elem_last) state_d = ST_RECV_B;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_RECV_B: begin
        rx_enable = 1'b1;
        tmo_run   = 1'b1;
        if (rx_valid) begin
          wr_en_b  = 1'b1;
          elem_inc = 1'b1;
          if (elem_last) state_d = ST_START;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_START: begin
        mult_start = 1'b1;
        state_d    = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (mult_done) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready && !tx_pend_q) begin
          tx_start = 1'b1;
          bsel_inc = 1'b1;
          if (bsel_last) begin
            elem_inc = 1'b1;
            if (elem_last) state_d = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        if (tx_ready && !tx_pend_q) begin
          tx_start = 1'b1;
          tx_err   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ERR && state_q != ST_ERR) error_d = 1'b1;

    // A byte arriving in the expiry cycle is taken and restarts the count.
    if (!tmo_run || rx_valid || state_d != state_q) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= 4'd0;
      error_q   <= 1'b0;
      tmo_q     <= '0;
      tx_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      error_q   <= error_d;
      tmo_q     <= tmo_d;
      tx_pend_q <= tx_start;
    end
  end

  assign res_addr    = elem;
  assign wr_addr     = elem;
  assign tx_byte_sel = 2'(bsel);
  assign matrix_size = n_q;
  assign state       = state_q;
  assign error       = error_q;

endmodule

// File: tb/tb_mm_seq_controller.sv
module tb_mm_seq_controller;

  localparam int TMO = 40;

  // ---------------- clock / reset / shared inputs ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       mult_done;

  always #5 clk = ~clk;

  // ---------------- DUT with 2 result bytes ----------------
  logic       rx_enable_2, tx_start_2, tx_err_2, wr_en_a_2, wr_en_b_2, mult_start_2, error_2;
  logic [1:0] tx_byte_sel_2;
  logic [5:0] res_addr_2, wr_addr_2;
  logic [3:0] matrix_size_2;
  logic [2:0] state_2;

  mm_seq_controller #(.MAX_N(8), .RES_BYTES(2), .TIMEOUT(TMO)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_enable(rx_enable_2), .tx_ready(tx_ready), .tx_start(tx_start_2),
    .tx_err(tx_err_2), .tx_byte_sel(tx_byte_sel_2), .res_addr(res_addr_2),
    .wr_en_a(wr_en_a_2), .wr_en_b(wr_en_b_2), .wr_addr(wr_addr_2),
    .mult_start(mult_start_2), .mult_done(mult_done),
    .matrix_size(matrix_size_2), .state(state_2), .error(error_2)
  );

  // ---------------- DUT with 4 result bytes ----------------
  logic       rx_enable_4, tx_start_4, tx_err_4, wr_en_a_4, wr_en_b_4, mult_start_4, error_4;
  logic [1:0] tx_byte_sel_4;
  logic [5:0] res_addr_4, wr_addr_4;
  logic [3:0] matrix_size_4;
  logic [2:0] state_4;

  mm_seq_controller #(.MAX_N(8), .RES_BYTES(4), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_enable(rx_enable_4), .tx_ready(tx_ready), .tx_start(tx_start_4),
    .tx_err(tx_err_4), .tx_byte_sel(tx_byte_sel_4), .res_addr(res_addr_4),
    .wr_en_a(wr_en_a_4), .wr_en_b(wr_en_b_4), .wr_addr(wr_addr_4),
    .mult_start(mult_start_4), .mult_done(mult_done),
    .matrix_size(matrix_size_4), .state(state_4), .error(error_4)
  );

  // ---------------- monitors (sample on falling edge) ----------------
  logic [8:0] wa_q2[$], wb_q2[$], tx_q2[$];
  logic [8:0] wa_q4[$], wb_q4[$], tx_q4[$];
  int         ms_cnt2, ms_cnt4;

  always @(negedge clk) begin
    if (wr_en_a_2)    wa_q2.push_back(9'(wr_addr_2));
    if (wr_en_b_2)    wb_q2.push_back(9'(wr_addr_2));
    if (tx_start_2)   tx_q2.push_back({tx_err_2, res_addr_2, tx_byte_sel_2});
    if (mult_start_2) ms_cnt2++;
    if (wr_en_a_4)    wa_q4.push_back(9'(wr_addr_4));
    if (wr_en_b_4)    wb_q4.push_back(9'(wr_addr_4));
    if (tx_start_4)   tx_q4.push_back({tx_err_4, res_addr_4, tx_byte_sel_4});
    if (mult_start_4) ms_cnt4++;
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic clear_mon();
    wa_q2.delete(); wb_q2.delete(); tx_q2.delete();
    wa_q4.delete(); wb_q4.delete(); tx_q4.delete();
    ms_cnt2 = 0; ms_cnt4 = 0;
  endtask

  // obs_q holds write addresses; expect 0..n*n-1 in order.
  task automatic check_wr(input string tag, input int n);
    exp_q.delete();
    for (int e = 0; e < n * n; e++) exp_q.push_back(9'(e));
    chk({tag, "_cnt"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk(tag, obs_q[i], exp_q[i]);
  endtask

  // obs_q holds tx strobes; expect element-major, byte 0 (MSB) first, no err.
  task automatic check_tx(input string tag, input int n, input int rb);
    exp_q.delete();
    for (int e = 0; e < n * n; e++)
      for (int b = 0; b < rb; b++) exp_q.push_back({1'b0, 6'(e), 2'(b)});
    chk({tag, "_cnt"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk(tag, obs_q[i], exp_q[i]);
  endtask

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input int na, input int nb);
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int i = 0; i < na; i++) send_byte(8'($urandom_range(0, 255)));
    for (int i = 0; i < nb; i++) send_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic pulse_done();
    mult_done = 1'b1;
    @(posedge clk); #1;
    mult_done = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max_cyc);
    int k = 0;
    while (!(state_2 == s && state_4 == s) && k < max_cyc) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_st2"}, state_2, s);
    chk({tag, "_st4"}, state_4, s);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; mult_done = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",  state_2, 3'd0);
    chk("rst_size",   matrix_size_2, 4'd0);
    chk("rst_error",  error_2, 1'b0);
    chk("rst_tx",     tx_start_2, 1'b0);
    chk("rst_wr",     {wr_en_a_2, wr_en_b_2, mult_start_2}, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- N=3 full frame ----
    clear_mon();
    send_frame(3, 9, 9);
    wait_state("n3_comp", 3'd5, 10);
    chk("n3_size", matrix_size_2, 4'd3);
    chk("n3_mstart2", ms_cnt2, 1);
    chk("n3_mstart4", ms_cnt4, 1);
    chk("n3_rxen_comp", rx_enable_2, 1'b0);
    obs_q = wa_q2; check_wr("n3_wa", 3);
    obs_q = wb_q2; check_wr("n3_wb", 3);
    // byte arriving during COMPUTE is ignored
    send_byte(8'hA5);
    chk("n3_ign_st", state_2, 3'd5);
    chk("n3_ign_wr", wa_q2.size() + wb_q2.size(), 18);
    // hold transmitter busy: no strobes may appear
    tx_ready = 1'b0;
    pulse_done();
    repeat (10) @(posedge clk);
    #1;
    chk("n3_hold_st", state_2, 3'd6);
    chk("n3_hold_tx", tx_q2.size(), 0);
    tx_ready = 1'b1;
    wait_state("n3_idle", 3'd0, 200);
    obs_q = tx_q2; check_tx("n3_tx2", 3, 2);
    obs_q = tx_q4; check_tx("n3_tx4", 3, 4);

    // ---- N=8 (maximum) full frame ----
    clear_mon();
    send_frame(8, 64, 64);
    wait_state("n8_comp", 3'd5, 10);
    chk("n8_size", matrix_size_4, 4'd8);
    obs_q = wa_q4; check_wr("n8_wa", 8);
    obs_q = wb_q4; check_wr("n8_wb", 8);
    pulse_done();
    wait_state("n8_idle", 3'd0, 1200);
    obs_q = tx_q2; check_tx("n8_tx2", 8, 2);
    obs_q = tx_q4; check_tx("n8_tx4", 8, 4);

    // ---- bad sizes: 0, 9 (>MAX_N), 0x13 (upper nibble set) ----
    clear_mon();
    send_byte(8'hA5); send_byte(8'h00);
    wait_state("sz0_idle", 3'd0, 10);
    chk("sz0_tx_cnt", tx_q2.size(), 1);
    if (tx_q2.size() > 0) chk("sz0_tx_err", tx_q2[0][8], 1'b1);
    chk("sz0_error", error_2, 1'b1);
    clear_mon();
    send_byte(8'hA5); send_byte(8'h09);
    wait_state("sz9_idle", 3'd0, 10);
    chk("sz9_tx_cnt", tx_q4.size(), 1);
    if (tx_q4.size() > 0) chk("sz9_tx_err", tx_q4[0][8], 1'b1);
    chk("sz9_error", error_4, 1'b1);
    chk("sz9_wr", wa_q2.size(), 0);
    clear_mon();
    send_byte(8'hA5); send_byte(8'h13);
    chk("sz13_error", error_2, 1'b1);
    chk("sz13_tx_cnt", tx_q2.size(), 1);

    // ---- garbage before SYNC; error stays until SYNC ----
    clear_mon();
    send_byte(8'h12); send_byte(8'h34);
    chk("garb_wr", wa_q2.size(), 0);
    chk("garb_st", state_2, 3'd0);
    chk("garb_err_sticky", error_2, 1'b1);
    send_byte(8'hA5);
    chk("sync_clr_err", error_2, 1'b0);
    chk("sync_st", state_2, 3'd1);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    wait_state("n2_comp", 3'd5, 10);
    obs_q = wa_q2; check_wr("n2_wa", 2);
    obs_q = wb_q2; check_wr("n2_wb", 2);
    pulse_done();
    wait_state("n2_idle", 3'd0, 100);
    obs_q = tx_q2; check_tx("n2_tx2", 2, 2);

    // ---- inter-byte timeout in RECV_A ----
    clear_mon();
    send_frame(3, 4, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("tmo_pre_st", state_2, 3'd2);
    chk("tmo_pre_err", error_2, 1'b0);
    wait_state("tmo_idle", 3'd0, 40);
    chk("tmo_tx_cnt", tx_q2.size(), 1);
    if (tx_q2.size() > 0) chk("tmo_tx_err", tx_q2[0][8], 1'b1);
    chk("tmo_error", error_2, 1'b1);
    chk("tmo_wa", wa_q2.size(), 4);

    // ---- reset during SEND after 5 bytes ----
    clear_mon();
    send_byte(8'hA5);
    chk("rs_sync_clr", error_4, 1'b0);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    wait_state("rs_comp", 3'd5, 10);
    pulse_done();
    begin
      int k = 0;
      while (tx_q2.size() < 5 && k < 100) begin
        @(posedge clk); #2;
        k++;
      end
    end
    chk("rs_at5", tx_q2.size(), 5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rs_st2", state_2, 3'd0);
    chk("rs_st4", state_4, 3'd0);
    chk("rs_tx", {tx_start_2, tx_start_4, tx_err_2}, 3'b000);
    chk("rs_size", matrix_size_2, 4'd0);
    chk("rs_strobes", {wr_en_a_2, wr_en_b_2, mult_start_2}, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rs_no_tx2", tx_q2.size(), 5);
    chk("rs_no_tx4", tx_q4.size(), 5);
    chk("rs_idle", state_4, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
